// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the oversampling
// receiver, so that both directions agree on state encodings, parity
// polarity and the smallest usable bit period.
//   uart_state_t  : frame FSM states (IDLE/START/DATA/PARITY/STOP)
//   PAR_EVEN/ODD  : meaning of the PAR_TYP configuration bit
//   PRESCALE_MIN  : prescale values below this are clamped up to it
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // A one-cycle bit period cannot be held by the registered line, so
  // 0 and 1 are both treated as 2.
  localparam int PRESCALE_MIN = 2;

endpackage

// File: rtl/uart_tx_os_baud.sv
// Loadable baud counter for the oversampled transmitter.
// The prescale value is captured on load (clamped to PRESCALE_MIN) and the
// counter restarts from 0. While enabled it counts 0..ps-1 and raises
// bit_tick in the cycle where it holds ps-1, then wraps to 0.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture prescale and clear the counter (frame accept)
//   en         : count while a frame is in flight
//   prescale   : raw prescale from the configuration input
//   bit_tick   : last cycle of the current bit period
module uart_tx_os_baud
  import uart_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      en,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      bit_tick
);

  localparam logic [PRESCALE_WIDTH-1:0] PS_MIN = PRESCALE_WIDTH'(PRESCALE_MIN);

  logic [PRESCALE_WIDTH-1:0] ps_q;
  logic [PRESCALE_WIDTH-1:0] cnt_q;
  logic [PRESCALE_WIDTH-1:0] ps_clamped;

  always_comb begin
    ps_clamped = (prescale < PS_MIN) ? PS_MIN : prescale;
  end

  // ps_q >= 2 always, so ps_q-1 never underflows and the largest value
  // (all ones) only ever counts up to all-ones minus one.
  assign bit_tick = en && (cnt_q == (ps_q - 1'b1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q  <= PS_MIN;
      cnt_q <= '0;
    end else if (load) begin
      ps_q  <= ps_clamped;
      cnt_q <= '0;
    end else if (en) begin
      if (bit_tick) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_os.sv
// Oversampled UART transmitter. Sends one DATA_WIDTH word per frame:
// start (0), data LSB first, optional parity, stop (1). Each bit lasts
// PRESCALE cycles of the oversampling clock shared with the receiver.
// Ports:
//   CLK, RST    : clock, asynchronous active-high reset
//   P_DATA      : word to send
//   DATA_VALID  : send request
//   PRESCALE    : clocks per serial bit (0 and 1 act as 2)
//   PAR_EN      : append a parity bit
//   PAR_TYP     : PAR_EVEN / PAR_ODD
//   TX_OUT      : registered serial line, idle high
//   BUSY        : registered, high while a frame is in flight
//   state_dbg   : current FSM state, for observation only
//
// Handshake: a request is taken at a rising edge where the FSM is IDLE and
// DATA_VALID=1; P_DATA and all configuration are captured at that edge and
// BUSY rises in the following cycle. DATA_VALID while BUSY=1 is dropped, not
// queued. Holding DATA_VALID high re-triggers on the single IDLE cycle that
// follows every frame.
module uart_tx_os
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      DATA_VALID,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  output logic                      TX_OUT,
  output logic                      BUSY,
  output uart_state_t               state_dbg
);

  localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  uart_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  accept;
  logic                  bit_tick;

  assign accept    = (state_q == IDLE) && DATA_VALID;
  assign TX_OUT    = tx_q;
  assign BUSY      = busy_q;
  assign state_dbg = state_q;

  uart_tx_os_baud #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_baud (
    .clk      (CLK),
    .rst      (RST),
    .load     (accept),
    .en       (state_q != IDLE),
    .prescale (PRESCALE),
    .bit_tick (bit_tick)
  );

  // Next-state logic also computes the next line level, so TX_OUT comes
  // straight from a flop and changes exactly on the state boundary.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (DATA_VALID) begin
          state_d   = START;
          shift_d   = P_DATA;
          bit_cnt_d = '0;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = shift_d[0];
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_tick) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  // Parity is fixed at accept from the captured word, so later P_DATA or
  // PAR_TYP changes cannot reach the current frame.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else if (accept) begin
      par_en_q  <= PAR_EN;
      par_bit_q <= (PAR_TYP == PAR_ODD) ? ~^P_DATA : ^P_DATA;
    end
  end

endmodule
